// File: rtl/run_scan_pkg.sv
// Shared types and width-derived constants for the run-length scan controller.
package run_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned RUN_W_DEF = 4;
  localparam int unsigned EVT_W_DEF = 8;

  // All-ones value of a w-bit field, valid for w below 32
  function automatic int unsigned max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned RUN_MAX_DEF = max_of(RUN_W_DEF);
  localparam int unsigned EVT_MAX_DEF = max_of(EVT_W_DEF);

endpackage

// File: rtl/run_scan_ctrl_run_tracker.sv
// Tracks the length of the current run of equal bits, saturating at rl,
// and flags the single bit that first brings a run up to rl.
module run_tracker
  import run_scan_pkg::*;
#(
  parameter int unsigned RUN_W = RUN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             a,
  input  logic [RUN_W-1:0] rl,
  output logic             det,
  output logic             evt_one_c,
  output logic             evt_zero_c
);

  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_n;
  logic             last;
  logic             restart_c;
  logic             hit_c;

  // Next run length and the qualifying-event pulse for the bit on a
  always_comb begin
    restart_c = (run == '0) || (a != last);
    run_n     = RUN_W'(1);
    if (!restart_c) begin
      if (run >= rl) begin
        run_n = rl;
      end else begin
        run_n = run + RUN_W'(1);
      end
    end
    hit_c      = enable && (run_n == rl) && (restart_c || (run < rl));
    evt_one_c  = hit_c && a;
    evt_zero_c = hit_c && !a;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      run  <= '0;
      last <= 1'b0;
      det  <= 1'b0;
    end else if (clear) begin
      run  <= '0;
      last <= 1'b0;
      det  <= 1'b0;
    end else if (enable) begin
      run  <= run_n;
      last <= a;
      det  <= (run_n >= rl);
    end
  end

endmodule

// File: rtl/run_scan_ctrl.sv
// Sequences one bounded scan window per start and returns saturating
// ones/zeros run-event counts through a valid/ready result handshake.
module run_scan_ctrl
  import run_scan_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned RUN_W = RUN_W_DEF,
  parameter int unsigned EVT_W = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] win_len,
  input  logic [RUN_W-1:0] run_len,
  input  logic             a,
  input  logic             a_valid,
  output logic             busy,
  output logic             det,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [EVT_W-1:0] ones_evt,
  output logic [EVT_W-1:0] zeros_evt,
  output logic             evt_ovf
);

  localparam logic [EVT_W-1:0] EVT_MAX = EVT_W'(max_of(EVT_W));

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_n;
  logic [RUN_W-1:0] rl;
  logic [RUN_W-1:0] rl_n;
  logic [EVT_W-1:0] ones_n;
  logic [EVT_W-1:0] zeros_n;
  logic             ovf_n;
  logic             busy_n;
  logic             res_valid_n;
  logic             trk_clear_c;
  logic             trk_en_c;
  logic             evt_one_c;
  logic             evt_zero_c;

  assign trk_en_c    = (state == S_SCAN) && a_valid && !abort;
  // Tracker is held clear throughout IDLE so det reads 0 there
  assign trk_clear_c = (state == S_IDLE) || (state_n == S_IDLE);

  run_tracker #(
    .RUN_W (RUN_W)
  ) u_run_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (trk_clear_c),
    .enable     (trk_en_c),
    .a          (a),
    .rl         (rl),
    .det        (det),
    .evt_one_c  (evt_one_c),
    .evt_zero_c (evt_zero_c)
  );

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    rl_n        = rl;
    ones_n      = ones_evt;
    zeros_n     = zeros_evt;
    ovf_n       = evt_ovf;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          remaining_n = win_len;
          rl_n        = (run_len == '0) ? RUN_W'(1) : run_len;
          ones_n      = '0;
          zeros_n     = '0;
          ovf_n       = 1'b0;
          state_n     = (win_len == '0) ? S_REPORT : S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (a_valid) begin
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_n = S_REPORT;
          end
          // Saturating event counters with sticky overflow
          if (evt_one_c) begin
            if (ones_evt == EVT_MAX) ovf_n = 1'b1;
            else ones_n = ones_evt + EVT_W'(1);
          end
          if (evt_zero_c) begin
            if (zeros_evt == EVT_MAX) ovf_n = 1'b1;
            else zeros_n = zeros_evt + EVT_W'(1);
          end
        end
      end
      S_REPORT: begin
        if (abort || res_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n      = (state_n != S_IDLE);
    res_valid_n = (state_n == S_REPORT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      rl        <= '0;
      ones_evt  <= '0;
      zeros_evt <= '0;
      evt_ovf   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      rl        <= rl_n;
      ones_evt  <= ones_n;
      zeros_evt <= zeros_n;
      evt_ovf   <= ovf_n;
      busy      <= busy_n;
      res_valid <= res_valid_n;
    end
  end

endmodule

// File: tb/tb_run_scan_ctrl.sv
// Self-checking bench: vector table, directed corner sequences and random
// scans against a run-list reference model, on an 8-bit and a 2-bit counter DUT.
module tb_run_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, a, a_valid, res_ready;
  logic [7:0] win_len;
  logic [3:0] run_len;

  logic       busy, det, res_valid, evt_ovf;
  logic [7:0] ones_evt, zeros_evt;
  logic       busy2, det2, res_valid2, evt_ovf2;
  logic [1:0] ones_evt2, zeros_evt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_scan_ctrl #(.CNT_W(8), .RUN_W(4), .EVT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_len(win_len), .run_len(run_len), .a(a), .a_valid(a_valid),
    .busy(busy), .det(det), .res_valid(res_valid), .res_ready(res_ready),
    .ones_evt(ones_evt), .zeros_evt(zeros_evt), .evt_ovf(evt_ovf)
  );

  run_scan_ctrl #(.CNT_W(8), .RUN_W(4), .EVT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .win_len(win_len), .run_len(run_len), .a(a), .a_valid(a_valid),
    .busy(busy2), .det(det2), .res_valid(res_valid2), .res_ready(res_ready),
    .ones_evt(ones_evt2), .zeros_evt(zeros_evt2), .evt_ovf(evt_ovf2)
  );

  // Reference model: 0 idle, 1 scanning, 2 reporting; counts recomputed from the sampled bits
  int m_st, m_rem, m_rl, raw1, raw0;
  bit m_det;
  bit m_bits[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void recount();
    int len = 0;
    raw1 = 0;
    raw0 = 0;
    for (int i = 0; i < m_bits.size(); i++) begin
      if (i > 0 && m_bits[i] == m_bits[i-1]) len++;
      else len = 1;
      if (len == m_rl) begin
        if (m_bits[i]) raw1++;
        else raw0++;
      end
    end
    m_det = (len >= m_rl);
  endfunction

  function automatic void model_step();
    if (!reset) begin
      m_st = 0; m_rem = 0; m_rl = 0; raw1 = 0; raw0 = 0; m_det = 0;
      m_bits.delete();
    end else begin
      case (m_st)
        0: if (start) begin
          m_rem = int'(win_len);
          m_rl  = (run_len == 0) ? 1 : int'(run_len);
          m_bits.delete();
          raw1 = 0; raw0 = 0; m_det = 0;
          m_st = (win_len == 0) ? 2 : 1;
        end
        1: if (abort) begin
          m_st = 0; m_det = 0;
        end else if (a_valid) begin
          m_bits.push_back(a);
          recount();
          if (m_rem == 1) m_st = 2;
          m_rem--;
        end
        default: if (abort || res_ready) begin
          m_st = 0; m_det = 0;
        end
      endcase
    end
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock: advance the model at the edge, then compare both DUTs 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("busy", int'(busy), int'(m_st != 0));
    chk("res_valid", int'(res_valid), int'(m_st == 2));
    chk("det", int'(det), int'(m_det));
    chk("ones_evt", int'(ones_evt), sat(raw1, 255));
    chk("zeros_evt", int'(zeros_evt), sat(raw0, 255));
    chk("evt_ovf", int'(evt_ovf), int'(raw1 > 255 || raw0 > 255));
    chk("busy2", int'(busy2), int'(m_st != 0));
    chk("res_valid2", int'(res_valid2), int'(m_st == 2));
    chk("det2", int'(det2), int'(m_det));
    chk("ones_evt2", int'(ones_evt2), sat(raw1, 3));
    chk("zeros_evt2", int'(zeros_evt2), sat(raw0, 3));
    chk("evt_ovf2", int'(evt_ovf2), int'(raw1 > 3 || raw0 > 3));
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; a = 0; a_valid = 0; res_ready = 0;
  endtask

  task automatic begin_scan(input int win, input int rl);
    win_len = 8'(win); run_len = 4'(rl); start = 1;
    tick();
    start = 0;
  endtask

  task automatic send_bit(input bit b, input bit stall);
    a = b; a_valid = 1;
    tick();
    a_valid = 0;
    if (stall) begin
      a = ~b;
      tick();
    end
  endtask

  task automatic accept_result();
    res_ready = 1;
    tick();
    res_ready = 0;
  endtask

  typedef struct {
    logic       start, a, a_valid, res_ready;
    logic [7:0] win;
    logic [3:0] rl;
    logic       e_busy, e_det, e_rv;
    int         e_ones, e_zeros;
  } vec_t;

  vec_t tv[12];
  bit   pat[10];
  bit   alt[10];

  initial begin
    reset = 0; win_len = 0; run_len = 0;
    idle_inputs();
    tick();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_counts", int'(ones_evt) + int'(zeros_evt) + int'(evt_ovf), 0);
    reset = 1;
    tick();

    // rl=4, window 10, bits 1111100001: det after bits 4,5 and 9; result after bit 10
    pat = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    tv[0] = '{1, 0, 0, 0, 8'd10, 4'd4, 1, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      tv[i+1] = '{0, pat[i], 1, 0, 8'd0, 4'd0, 1, (i == 3 || i == 4 || i == 8),
                  (i == 9), (i >= 3) ? 1 : 0, (i >= 8) ? 1 : 0};
    end
    tv[11] = '{0, 0, 0, 1, 8'd0, 4'd0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 12; i++) begin
      start = tv[i].start; a = tv[i].a; a_valid = tv[i].a_valid;
      res_ready = tv[i].res_ready; win_len = tv[i].win; run_len = tv[i].rl;
      tick();
      chk($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].e_busy));
      chk($sformatf("tv%0d_det", i), int'(det), int'(tv[i].e_det));
      chk($sformatf("tv%0d_rv", i), int'(res_valid), int'(tv[i].e_rv));
      chk($sformatf("tv%0d_ones", i), int'(ones_evt), tv[i].e_ones);
      chk($sformatf("tv%0d_zeros", i), int'(zeros_evt), tv[i].e_zeros);
    end
    idle_inputs();

    // Same stream with a stall after every bit
    begin_scan(10, 4);
    for (int i = 0; i < 10; i++) send_bit(pat[i], i != 9);
    chk("stall_rv", int'(res_valid), 1);
    chk("stall_ones", int'(ones_evt), 1);
    chk("stall_zeros", int'(zeros_evt), 1);
    accept_result();

    // rl=1: every new run counts once
    begin_scan(6, 1);
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
    chk("rl1_ones", int'(ones_evt), 3);
    chk("rl1_zeros", int'(zeros_evt), 2);
    accept_result();

    // Empty window, result held under backpressure
    begin_scan(0, 3);
    chk("win0_rv", int'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("win0_hold_rv", int'(res_valid), 1);
      chk("win0_hold_cnt", int'(ones_evt) + int'(zeros_evt), 0);
    end
    accept_result();
    chk("win0_done_busy", int'(busy), 0);
    chk("win0_done_rv", int'(res_valid), 0);

    // Alternating bits, rl=0 (forced to 1): 2-bit counters saturate
    alt = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    begin_scan(10, 0);
    for (int i = 0; i < 10; i++) send_bit(alt[i], 0);
    chk("sat_ones2", int'(ones_evt2), 3);
    chk("sat_zeros2", int'(zeros_evt2), 3);
    chk("sat_ovf2", int'(evt_ovf2), 1);
    chk("sat_ones8", int'(ones_evt), 5);
    chk("sat_ovf8", int'(evt_ovf), 0);
    accept_result();

    // Abort after three bits, together with a valid bit
    begin_scan(10, 2);
    send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
    abort = 1; a = 0; a_valid = 1;
    tick();
    idle_inputs();
    chk("abort_busy", int'(busy), 0);
    chk("abort_rv", int'(res_valid), 0);
    tick();
    chk("abort_rv_later", int'(res_valid), 0);

    // Start ignored in REPORT, then reset while reporting
    begin_scan(2, 1);
    send_bit(1, 0); send_bit(0, 0);
    start = 1; win_len = 8'd5; run_len = 4'd2;
    tick();
    start = 0;
    chk("rep_start_rv", int'(res_valid), 1);
    chk("rep_start_ones", int'(ones_evt), 1);
    reset = 0;
    tick();
    reset = 1;
    chk("rst_rep_outs", int'(busy) + int'(det) + int'(res_valid) + int'(evt_ovf), 0);
    chk("rst_rep_cnts", int'(ones_evt) + int'(zeros_evt), 0);
    tick();
    chk("rst_rep_idle", int'(busy), 0);

    // Random scans with stalls, sticky runs, rare aborts, stray starts and resets
    for (int s = 0; s < 60; s++) begin
      int  win, budget;
      bit  prev;
      win = (s % 15 == 7) ? 200 : int'($urandom_range(0, 30));
      begin_scan(win, int'($urandom_range(0, 15)) % ((s % 3 == 0) ? 4 : 16));
      prev = 1'($urandom);
      budget = 0;
      while (m_st != 0 && budget < 2000) begin
        a_valid   = ($urandom % 4) != 0;
        prev      = (($urandom % 4) == 0) ? ~prev : prev;
        a         = prev;
        abort     = ($urandom % 150) == 0;
        start     = ($urandom % 16) == 0;
        res_ready = (m_st == 2) && (($urandom % 3) == 0);
        reset     = ($urandom % 800) != 0;
        tick();
        reset = 1;
        budget++;
      end
      idle_inputs();
      if (budget >= 2000) chk("random_timeout", budget, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
